// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, ALU codes,
// FSM states and regfile write-data mux selects.
package cpu_pkg;

  localparam logic [6:0] OPCODE_R     = 7'b0110011;
  localparam logic [6:0] OPCODE_I     = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [6:0] OPCODE_B     = 7'b1100011;
  localparam logic [6:0] OPCODE_S     = 7'b0100011;
  localparam logic [6:0] OPCODE_L     = 7'b0000011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    R_EXE  = 4'd2,
    I_EXE  = 4'd3,
    LU_EXE = 4'd4,
    AU_EXE = 4'd5,
    J_EXE  = 4'd6,
    JL_EXE = 4'd7,
    B_EXE  = 4'd8,
    S_EXE  = 4'd9,
    S_MEM  = 4'd10,
    L_EXE  = 4'd11,
    L_MEM  = 4'd12,
    L_WB   = 4'd13,
    SKIP   = 4'd14
  } state_e;

  localparam logic [2:0] RFWD_ALU   = 3'd0;
  localparam logic [2:0] RFWD_BUS   = 3'd1;
  localparam logic [2:0] RFWD_IMM   = 3'd2;
  localparam logic [2:0] RFWD_AUIPC = 3'd3;
  localparam logic [2:0] RFWD_PC4   = 3'd4;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle control unit (master) and the datapath (slave).
// busReady is a completion pulse: the datapath raises it in the cycle the requested
// busWe/busRe access finishes; the control unit holds its strobe until then.
interface multicycle_control_unit_if;
  import cpu_pkg::*;

  logic [31:0] instrCode;
  logic        busReady;
  logic        pcEn;
  logic        irWe;
  logic        regFileWe;
  logic        aluSrcMuxSel;
  logic [3:0]  aluControl;
  logic [2:0]  rfWdSrcMuxSel;
  logic        busWe;
  logic        busRe;
  logic        branch;
  logic        jal;
  logic        jalr;
  state_e      state;

  modport master (
    input  instrCode, busReady,
    output pcEn, irWe, regFileWe, aluSrcMuxSel, aluControl, rfWdSrcMuxSel,
           busWe, busRe, branch, jal, jalr, state
  );

  modport slave (
    output instrCode, busReady,
    input  pcEn, irWe, regFileWe, aluSrcMuxSel, aluControl, rfWdSrcMuxSel,
           busWe, busRe, branch, jal, jalr, state
  );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Maps {bit30, funct3} to an ALU operation; bit30 selects SUB and SRA.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic       bit30,
  input  logic [2:0] funct3,
  output alu_op_e    alu_op
);
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = bit30 ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: only the state register is clocked; every
// enable is decoded combinationally from the current state and instruction.
module multicycle_control_unit
  import cpu_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  multicycle_control_unit_if.master      bus
);
  state_e     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       dec_bit30;
  alu_op_e    dec_op;
  logic       unused_bits;

  assign opcode      = bus.instrCode[6:0];
  assign funct3      = bus.instrCode[14:12];
  assign unused_bits = ^{bus.instrCode[31], bus.instrCode[29:15], bus.instrCode[11:7]};

  // Immediate ops only honour bit30 for shifts, so ADDI with imm[10]=1 stays ADD.
  assign dec_bit30 = (state_q == I_EXE) ? (bus.instrCode[30] & (funct3 == 3'b101))
                                        : bus.instrCode[30];

  alu_decoder u_alu_decoder (
    .bit30  (dec_bit30),
    .funct3 (funct3),
    .alu_op (dec_op)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.pcEn          = 1'b0;
    bus.irWe          = 1'b0;
    bus.regFileWe     = 1'b0;
    bus.aluSrcMuxSel  = 1'b0;
    bus.aluControl    = ALU_ADD;
    bus.rfWdSrcMuxSel = RFWD_ALU;
    bus.busWe         = 1'b0;
    bus.busRe         = 1'b0;
    bus.branch        = 1'b0;
    bus.jal           = 1'b0;
    bus.jalr          = 1'b0;
    case (state_q)
      FETCH: begin
        bus.irWe = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        case (opcode)
          OPCODE_R:     state_d = R_EXE;
          OPCODE_I:     state_d = I_EXE;
          OPCODE_LUI:   state_d = LU_EXE;
          OPCODE_AUIPC: state_d = AU_EXE;
          OPCODE_JAL:   state_d = J_EXE;
          OPCODE_JALR:  state_d = JL_EXE;
          OPCODE_B:     state_d = B_EXE;
          OPCODE_S:     state_d = S_EXE;
          OPCODE_L:     state_d = L_EXE;
          default:      state_d = SKIP;
        endcase
      end
      R_EXE: begin
        bus.regFileWe  = 1'b1;
        bus.pcEn       = 1'b1;
        bus.aluControl = dec_op;
        state_d        = FETCH;
      end
      I_EXE: begin
        bus.aluSrcMuxSel = 1'b1;
        bus.regFileWe    = 1'b1;
        bus.pcEn         = 1'b1;
        bus.aluControl   = dec_op;
        state_d          = FETCH;
      end
      LU_EXE, AU_EXE: begin
        bus.regFileWe     = 1'b1;
        bus.pcEn          = 1'b1;
        bus.rfWdSrcMuxSel = (state_q == LU_EXE) ? RFWD_IMM : RFWD_AUIPC;
        state_d           = FETCH;
      end
      J_EXE, JL_EXE: begin
        bus.jal           = (state_q == J_EXE);
        bus.jalr          = (state_q == JL_EXE);
        bus.aluSrcMuxSel  = (state_q == JL_EXE);
        bus.regFileWe     = 1'b1;
        bus.pcEn          = 1'b1;
        bus.rfWdSrcMuxSel = RFWD_PC4;
        state_d           = FETCH;
      end
      B_EXE: begin
        bus.branch     = 1'b1;
        bus.pcEn       = 1'b1;
        bus.aluControl = {1'b0, funct3};
        state_d        = FETCH;
      end
      S_EXE, L_EXE: begin
        bus.aluSrcMuxSel = 1'b1;
        state_d          = (state_q == S_EXE) ? S_MEM : L_MEM;
      end
      S_MEM: begin
        bus.busWe = 1'b1;
        // The PC advances in the completion cycle itself; no trailing step for stores.
        if (bus.busReady) begin
          bus.pcEn = 1'b1;
          state_d  = FETCH;
        end
      end
      L_MEM: begin
        bus.busRe = 1'b1;
        if (bus.busReady) state_d = L_WB;
      end
      L_WB: begin
        bus.regFileWe     = 1'b1;
        bus.rfWdSrcMuxSel = RFWD_BUS;
        bus.pcEn          = 1'b1;
        state_d           = FETCH;
      end
      SKIP: begin
        bus.pcEn = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks instructions cycle by cycle and
// compares state plus every control output against hand-computed values.
module tb_multicycle_control_unit;
  import cpu_pkg::*;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  multicycle_control_unit_if bus ();

  multicycle_control_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, obs, exp);
    end
  endtask

  // {state, pcEn, irWe, regFileWe, aluSrc, aluControl, rfWdSrc, busWe, busRe, branch, jal, jalr}
  function automatic logic [31:0] pk(input state_e st, input logic pc, input logic ir,
                                     input logic rf, input logic as, input logic [3:0] alu,
                                     input logic [2:0] sel, input logic we, input logic re,
                                     input logic br, input logic j, input logic jr);
    return {12'd0, st, pc, ir, rf, as, alu, sel, we, re, br, j, jr};
  endfunction

  function automatic logic [31:0] observed();
    return {12'd0, bus.state, bus.pcEn, bus.irWe, bus.regFileWe, bus.aluSrcMuxSel,
            bus.aluControl, bus.rfWdSrcMuxSel, bus.busWe, bus.busRe, bus.branch,
            bus.jal, bus.jalr};
  endfunction

  // driver tasks: inputs change 1 time unit after the edge, outputs sampled 1 unit later
  task automatic drive(input logic [31:0] instr, input logic rdy);
    bus.instrCode = instr;
    bus.busReady  = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic [31:0] exp);
    check_eq(tag, observed(), exp);
    step();
  endtask

  // plain 3-cycle instruction: FETCH, DECODE, then one EXE state
  task automatic run3(input string tag, input logic [31:0] instr, input logic [31:0] exe_exp);
    drive(instr, 1'b0);
    expect_cycle({tag, "_fetch"},  pk(FETCH,  0, 1, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    expect_cycle({tag, "_decode"}, pk(DECODE, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    expect_cycle({tag, "_exe"},    exe_exp);
    check_eq({tag, "_back"}, {28'd0, bus.state}, {28'd0, FETCH});
  endtask

  // invariants on every cycle outside reset
  always @(negedge clk) begin
    if (reset_n) begin
      check_eq("inv_rf_we", {31'd0, bus.regFileWe & bus.busWe}, 32'd0);
      check_eq("inv_we_re", {31'd0, bus.busWe & bus.busRe}, 32'd0);
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.instrCode = 32'h0000_0013;
    bus.busReady  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;

    // 1: reset mid-stream, held for two edges
    drive(32'h0020_81B3, 1'b0);
    step();
    step();
    check_eq("pre_reset_state", {28'd0, bus.state}, {28'd0, R_EXE});
    reset_n = 1'b0;
    step();
    step();
    check_eq("reset_outputs", observed(), pk(FETCH, 0, 1, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    #1;

    // 2/3: ALU register and immediate forms
    run3("add",  32'h0020_81B3, pk(R_EXE, 1, 0, 1, 0, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    run3("srai", 32'h4020_D193, pk(I_EXE, 1, 0, 1, 1, 4'd4, 3'd0, 0, 0, 0, 0, 0));
    run3("sub",  32'h4020_81B3, pk(R_EXE, 1, 0, 1, 0, 4'd1, 3'd0, 0, 0, 0, 0, 0));
    run3("addi_b30", 32'h4000_8093, pk(I_EXE, 1, 0, 1, 1, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    run3("sra",  32'h4020_D1B3, pk(R_EXE, 1, 0, 1, 0, 4'd4, 3'd0, 0, 0, 0, 0, 0));
    run3("and",  32'h0020_F1B3, pk(R_EXE, 1, 0, 1, 0, 4'd9, 3'd0, 0, 0, 0, 0, 0));
    run3("lui",  32'h1234_51B7, pk(LU_EXE, 1, 0, 1, 0, 4'd0, 3'd2, 0, 0, 0, 0, 0));
    run3("auipc", 32'h0000_1197, pk(AU_EXE, 1, 0, 1, 0, 4'd0, 3'd3, 0, 0, 0, 0, 0));
    run3("jal",  32'h0080_00EF, pk(J_EXE, 1, 0, 1, 0, 4'd0, 3'd4, 0, 0, 0, 1, 0));
    run3("jalr", 32'h0000_80E7, pk(JL_EXE, 1, 0, 1, 1, 4'd0, 3'd4, 0, 0, 0, 0, 1));
    run3("beq",  32'h0020_8463, pk(B_EXE, 1, 0, 0, 0, 4'd0, 3'd0, 0, 0, 1, 0, 0));
    run3("bne",  32'h0020_9463, pk(B_EXE, 1, 0, 0, 0, 4'd1, 3'd0, 0, 0, 1, 0, 0));

    // 4: store with three wait cycles
    drive(32'h0020_A023, 1'b1);
    expect_cycle("sw_fetch",  pk(FETCH,  0, 1, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    expect_cycle("sw_decode", pk(DECODE, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    drive(32'h0020_A023, 1'b0);
    expect_cycle("sw_exe",    pk(S_EXE,  0, 0, 0, 1, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      expect_cycle("sw_wait", pk(S_MEM, 0, 0, 0, 0, 4'd0, 3'd0, 1, 0, 0, 0, 0));
    drive(32'h0020_A023, 1'b1);
    expect_cycle("sw_ready",  pk(S_MEM,  1, 0, 0, 0, 4'd0, 3'd0, 1, 0, 0, 0, 0));
    drive(32'h0020_A023, 1'b0);
    check_eq("sw_back", {28'd0, bus.state}, {28'd0, FETCH});

    // 5: load with busReady already high -> 5 cycles
    drive(32'h0000_A183, 1'b1);
    expect_cycle("lw_fetch",  pk(FETCH,  0, 1, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    expect_cycle("lw_decode", pk(DECODE, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    expect_cycle("lw_exe",    pk(L_EXE,  0, 0, 0, 1, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    expect_cycle("lw_mem",    pk(L_MEM,  0, 0, 0, 0, 4'd0, 3'd0, 0, 1, 0, 0, 0));
    expect_cycle("lw_wb",     pk(L_WB,   1, 0, 1, 0, 4'd0, 3'd1, 0, 0, 0, 0, 0));
    check_eq("lw_back", {28'd0, bus.state}, {28'd0, FETCH});

    // 6: reset abandons a pending load, then an unknown opcode is skipped
    drive(32'h0000_A183, 1'b0);
    step();
    step();
    step();
    check_eq("lw_stall_state", {28'd0, bus.state}, {28'd0, L_MEM});
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    check_eq("lw_reset", observed(), pk(FETCH, 0, 1, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    run3("skip", 32'hFFFF_FFFF, pk(SKIP, 1, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
